// File: rtl/stream_wrr_scheduler.sv
// Weighted round-robin stream scheduler: grants one valid input for a burst of up to weight beats.
// Define STREAM_WRR_SCHEDULER_IDX_OUT_EN to add the idx_o port carrying the granted index.
module stream_wrr_scheduler #(
   parameter int unsigned NumInp      = 4,
   parameter type         payload_t   = logic,
   parameter int unsigned WeightWidth = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NumInp*WeightWidth-1:0] weight_i,
   input  payload_t                      inp_data_i [NumInp],
   input  logic [NumInp-1:0]             inp_valid_i,
   output logic [NumInp-1:0]             inp_ready_o,
   output payload_t                      oup_data_o,
   output logic                          oup_valid_o,
   input  logic                          oup_ready_i
`ifdef STREAM_WRR_SCHEDULER_IDX_OUT_EN
   ,
   output logic [$clog2(NumInp)-1:0]     idx_o
`endif
);

   localparam int unsigned IdxW = $clog2(NumInp);

   typedef enum logic [0:0] {StIdle, StGrant} state_e;

   state_e                 state_q, state_d;
   logic [IdxW-1:0]        ptr_q, ptr_d;
   logic [IdxW-1:0]        sel_q, sel_d;
   logic [WeightWidth-1:0] credit_q, credit_d;
   logic [IdxW-1:0]        pick;
   logic                   pick_found;
   logic [WeightWidth-1:0] pick_weight;
   logic [IdxW-1:0]        sel_inc;

   // First valid input scanning upward from ptr, wrapping at NumInp.
   always_comb begin : scan
      int unsigned     idx;
      logic [IdxW-1:0] cand;
      pick       = '0;
      pick_found = 1'b0;
      idx        = 0;
      cand       = '0;
      for (int unsigned k = 0; k < NumInp; k++) begin
         idx = 32'(ptr_q) + k;
         if (idx >= NumInp) begin
            idx = idx - NumInp;
         end
         cand = IdxW'(idx);
         if (!pick_found && inp_valid_i[cand]) begin
            pick_found = 1'b1;
            pick       = cand;
         end
      end
   end

   assign pick_weight = weight_i[32'(pick)*WeightWidth +: WeightWidth];
   assign sel_inc     = (sel_q == IdxW'(NumInp - 1)) ? '0 : sel_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      sel_d       = sel_q;
      credit_d    = credit_q;
      oup_valid_o = 1'b0;
      inp_ready_o = '0;
      unique case (state_q)
         StIdle: begin
            if (pick_found) begin
               sel_d    = pick;
               credit_d = (pick_weight == '0) ? WeightWidth'(1) : pick_weight;
               state_d  = StGrant;
            end
         end
         StGrant: begin
            oup_valid_o        = inp_valid_i[sel_q];
            inp_ready_o[sel_q] = oup_ready_i;
            if (!inp_valid_i[sel_q]) begin
               // Source drained: leftover credit is dropped.
               state_d  = StIdle;
               ptr_d    = sel_inc;
               credit_d = '0;
            end else if (oup_ready_i) begin
               credit_d = credit_q - WeightWidth'(1);
               if (credit_q == WeightWidth'(1)) begin
                  state_d = StIdle;
                  ptr_d   = sel_inc;
               end
            end
         end
         default: ;
      endcase
   end

   // sel resets to 0, so the idle output shows input 0 until the first grant.
   assign oup_data_o = inp_data_i[sel_q];

`ifdef STREAM_WRR_SCHEDULER_IDX_OUT_EN
   assign idx_o = (state_q == StGrant) ? sel_q : '0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= StIdle;
         ptr_q    <= '0;
         sel_q    <= '0;
         credit_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         sel_q    <= sel_d;
         credit_q <= credit_d;
      end
   end

endmodule

// File: tb/tb_stream_wrr_scheduler.sv
// Bench for stream_wrr_scheduler: per-cycle reference model of the grant rules plus directed
// scenarios with hand-computed beat orders and timings.
module tb_stream_wrr_scheduler;

   localparam int N   = 4;
   localparam int WW  = 4;
   localparam int BIG = 1000;

   typedef logic [7:0] data_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N*WW-1:0] weight;
   data_t           inp_data [N];
   logic [N-1:0]    inp_valid;
   logic [N-1:0]    inp_ready;
   data_t           oup_data;
   logic            oup_valid;
   logic            oup_ready;
`ifdef STREAM_WRR_SCHEDULER_IDX_OUT_EN
   logic [1:0]      idx;
`endif

   int budget [N] = '{default: 0};
   int sent   [N] = '{default: 0};
   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Reference model: owner -1 means no grant in progress.
   int m_owner  = -1;
   int m_ptr    = 0;
   int m_credit = 0;
   bit m_first  = 1'b1;

   int bsrc[$];
   int bcyc[$];

   stream_wrr_scheduler #(
      .NumInp     (N),
      .payload_t  (data_t),
      .WeightWidth(WW)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .weight_i   (weight),
      .inp_data_i (inp_data),
      .inp_valid_i(inp_valid),
      .inp_ready_o(inp_ready),
      .oup_data_o (oup_data),
      .oup_valid_o(oup_valid),
      .oup_ready_i(oup_ready)
`ifdef STREAM_WRR_SCHEDULER_IDX_OUT_EN
      ,
      .idx_o      (idx)
`endif
   );

   always #5 clk = ~clk;

   // Source i offers beats while sent < budget; payload encodes {source, beat count}.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         inp_valid[i] = sent[i] < budget[i];
         inp_data[i]  = data_t'(i * 16 + (sent[i] % 16));
      end
   end

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) begin
      int pick;
      int w;
      cyc <= cyc + 1;
      for (int i = 0; i < N; i++) begin
         if (inp_valid[i] && inp_ready[i]) sent[i] <= sent[i] + 1;
      end
      if (chk_en && oup_valid && oup_ready) begin
         bsrc.push_back(int'(oup_data[7:4]));
         bcyc.push_back(cyc);
      end
      pick = -1;
      w    = 0;
      if (rst) begin
         m_owner  <= -1;
         m_ptr    <= 0;
         m_credit <= 0;
         m_first  <= 1'b1;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (pick < 0 && inp_valid[(m_ptr + k) % N]) pick = (m_ptr + k) % N;
         end
         if (pick >= 0) begin
            w        = int'(weight[pick*WW +: WW]);
            m_owner  <= pick;
            m_credit <= (w == 0) ? 1 : w;
            m_first  <= 1'b0;
         end
      end else if (!inp_valid[m_owner]) begin
         m_owner <= -1;
         m_ptr   <= (m_owner + 1) % N;
      end else if (oup_ready) begin
         if (m_credit == 1) begin
            m_owner <= -1;
            m_ptr   <= (m_owner + 1) % N;
         end
         m_credit <= m_credit - 1;
      end
   end

   // Per-cycle comparison against the model, sampled mid-cycle.
   bit    pv = 1'b0;
   bit    pr = 1'b0;
   bit    p_rst = 1'b1;
   data_t pd = '0;
   always @(negedge clk) begin
      logic [N-1:0] er;
      bit           ev;
      if (chk_en) begin
         er = '0;
         ev = 1'b0;
         if (m_owner >= 0) begin
            ev           = inp_valid[m_owner];
            er[m_owner]  = oup_ready;
         end
         check("oup_valid", int'(oup_valid), int'(ev));
         check("inp_ready", int'(inp_ready), int'(er));
         if (m_owner >= 0) check("oup_data", int'(oup_data), int'(inp_data[m_owner]));
         else if (m_first) check("oup_data_idle", int'(oup_data), int'(inp_data[0]));
`ifdef STREAM_WRR_SCHEDULER_IDX_OUT_EN
         check("idx", int'(idx), (m_owner >= 0) ? m_owner : 0);
`endif
         if (pv && !pr && !p_rst && !rst) begin
            check("axi_hold_valid", int'(oup_valid), 1);
            check("axi_hold_data", int'(oup_data), int'(pd));
         end
      end
      pv    = oup_valid;
      pr    = oup_ready;
      pd    = oup_data;
      p_rst = rst;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic set_budget(input int i, input int n);
      budget[i] = sent[i] + n;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      for (int i = 0; i < N; i++) budget[i] = sent[i];
      tick(2);
      rst = 1'b0;
   endtask

   task automatic wait_beats(input int base, input int n, input int lim);
      int t = 0;
      while (bsrc.size() - base < n && t < lim) begin
         tick(1);
         t++;
      end
      check("beat_timeout", int'(bsrc.size() - base >= n), 1);
   endtask

   initial begin
      int base;
      int cstart;
      int s;
      int exp1 [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int exp2 [8]  = '{0, 1, 1, 1, 2, 3, 3, 0};
      int exp3 [4]  = '{2, 2, 1, 2};
      weight    = '0;
      oup_ready = 1'b1;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      check("rst_valid", int'(oup_valid), 0);
      check("rst_ready", int'(inp_ready), 0);
      tick(1);
      rst = 1'b0;

      // Equal weights of 2, everyone valid.
      weight = {4{4'd2}};
      base   = bsrc.size();
      for (int i = 0; i < N; i++) set_budget(i, BIG);
      check("s1_lat_idle", int'(oup_valid), 0);
      tick(1);
      check("s1_lat_grant", int'(oup_valid), 1);
      check("s1_first_data", int'(oup_data), 8'h00);
      wait_beats(base, 10, 60);
      for (int k = 0; k < 10; k++) check("s1_src", bsrc[base+k], exp1[k]);
      check("s1_gap_in", bcyc[base+1] - bcyc[base], 1);
      check("s1_gap_out", bcyc[base+2] - bcyc[base+1], 2);

      // Weights {1,3,0,2} for inputs 0..3.
      do_reset();
      weight = {4'd2, 4'd0, 4'd3, 4'd1};
      base   = bsrc.size();
      for (int i = 0; i < N; i++) set_budget(i, BIG);
      wait_beats(base, 8, 60);
      for (int k = 0; k < 8; k++) check("s2_src", bsrc[base+k], exp2[k]);

      // Input 2 drains after 2 of 4 beats; ptr moves to 3 so input 1 beats input 2.
      do_reset();
      weight = 16'h0400;
      base   = bsrc.size();
      set_budget(2, 2);
      wait_beats(base, 2, 20);
      check("s3_drained", int'(oup_valid), 0);
      tick(1);
      cstart = cyc;
      set_budget(1, 1);
      set_budget(2, 1);
      wait_beats(base, 4, 20);
      for (int k = 0; k < 4; k++) check("s3_src", bsrc[base+k], exp3[k]);
      check("s3_latency", bcyc[base+2] - cstart, 1);

      // Back-pressure for 5 cycles during a weight-3 grant on input 0.
      do_reset();
      weight    = 16'h0003;
      oup_ready = 1'b0;
      s         = sent[0];
      set_budget(0, BIG);
      tick(2);
      check("s4_valid", int'(oup_valid), 1);
      check("s4_data", int'(oup_data), s % 16);
      tick(5);
      check("s4_valid_held", int'(oup_valid), 1);
      check("s4_data_held", int'(oup_data), s % 16);
      check("s4_no_beat", sent[0], s);
      oup_ready = 1'b1;
      base      = bsrc.size();
      wait_beats(base, 4, 20);
      check("s4_gap0", bcyc[base+1] - bcyc[base], 1);
      check("s4_gap1", bcyc[base+2] - bcyc[base+1], 1);
      check("s4_gap2", bcyc[base+3] - bcyc[base+2], 2);

      // Reset in the 2nd beat of an input-1 burst while ptr sits at 3.
      do_reset();
      weight = 16'h0140;
      base   = bsrc.size();
      set_budget(2, 1);
      wait_beats(base, 1, 20);
      tick(2);
      set_budget(1, BIG);
      base = bsrc.size();
      wait_beats(base, 1, 20);
      check("s5_pre_src", bsrc[base], 1);
      rst = 1'b1;
      set_budget(3, BIG);
      tick(1);
      rst = 1'b0;
      check("s5_rst_valid", int'(oup_valid), 0);
      check("s5_rst_ready", int'(inp_ready), 0);
      base = bsrc.size();
      wait_beats(base, 1, 20);
      check("s5_post_src", bsrc[base], 1);

      tick(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stream_wrr_scheduler.md
STREAM_WRR_SCHEDULER -- requirements
Module: stream_wrr_scheduler

Interface
REQ-001: The block SHALL have parameter NumInp, default 4, meaning number of requesting input streams (2..16).
REQ-002: The block SHALL have parameter payload_t, default logic, meaning the payload type carried on every stream.
REQ-003: The block SHALL have parameter WeightWidth, default 4, meaning the bit width of each per-input weight.
REQ-004: The block SHALL have port clk_i  input  1  the single clock; all logic on its rising edge.
REQ-005: The block SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006: The block SHALL have port weight_i  input  NumInp*WeightWidth  per-input burst weight; input i uses slice [i*WeightWidth +: WeightWidth].
REQ-007: The block SHALL have port inp_data_i  input  NumInp x payload_t  input payloads.
REQ-008: The block SHALL have port inp_valid_i  input  NumInp  input valids.
REQ-009: The block SHALL have port inp_ready_o  output  NumInp  input readies.
REQ-010: The block SHALL have port oup_data_o  output  payload_t  granted payload.
REQ-011: The block SHALL have port oup_valid_o  output  1  output valid.
REQ-012: The block SHALL have port oup_ready_i  input  1  output ready.

Function
REQ-013: The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-014: In IDLE with any inp_valid_i set, it SHALL select the first valid index scanning ptr, ptr+1, ... modulo NumInp, latch it as sel, load credit = weight_i[sel] (weight 0 loads 1), and enter GRANT next cycle.
REQ-015: In IDLE, oup_valid_o and all inp_ready_o SHALL be 0; minimum latency from first valid in IDLE to oup_valid_o is one cycle.
REQ-016: In GRANT, oup_valid_o SHALL equal inp_valid_i[sel], oup_data_o SHALL equal inp_data_i[sel], inp_ready_o[sel] SHALL equal oup_ready_i, all other readies 0.
REQ-017: Combinational paths SHALL be limited to valid/data forward and ready backward for the latched sel; sel SHALL not change while in GRANT.
REQ-018: Each output handshake (oup_valid_o && oup_ready_i) SHALL decrement credit by 1.
REQ-019: GRANT SHALL exit to IDLE, with ptr = (sel+1) mod NumInp, when a handshake decrements credit to 0, or when inp_valid_i[sel] is 0 (source drained, remaining credit discarded).
REQ-020: weight_i changes SHALL affect only the next grant load, never an active burst.
REQ-021: Every release SHALL insert one IDLE cycle between bursts (sustained throughput WeightMax/(WeightMax+1)).
REQ-022: Output SHALL obey AXI rules: once oup_valid_o is 1 it stays 1 with stable data until handshake, given inputs obey the same rule.
REQ-023: With all inputs valid and equal weight W, each input SHALL receive exactly W beats per round in order 0,1,..,NumInp-1.

Reset
REQ-024: While rst_i is 1 at a clock edge: state IDLE, ptr 0, sel 0, credit 0.
REQ-025: During and after reset until first grant: oup_valid_o 0, inp_ready_o all 0, oup_data_o = inp_data_i[0].
REQ-026: Reset asserted mid-burst SHALL abandon the burst with no handshake in the reset cycle's following state; ptr restarts at 0.

Configuration
REQ-027: Macro STREAM_WRR_SCHEDULER_IDX_OUT_EN SHALL, when defined, add port idx_o  output  $clog2(NumInp)  equal to sel in GRANT and 0 in IDLE/reset.
REQ-028: Without STREAM_WRR_SCHEDULER_IDX_OUT_EN, idx_o SHALL not exist and all other behaviour SHALL be identical.

Verification
REQ-029: Reset then NumInp=4, all valid, weights all 2, oup_ready_i=1 -> beats from inputs 0,0,1,1,2,2,3,3,0,.. with one idle cycle between bursts.
REQ-030: Weights {1,3,0,2}, all valid continuously -> per-round beats 1,3,1,2 from inputs 0,1,2,3.
REQ-031: Input 2 only valid, weight 4, sends 2 beats then drops valid -> grant released after 2nd beat, ptr=3, next request from input 1 served after one IDLE cycle.
REQ-032: oup_ready_i held 0 for 5 cycles during GRANT -> oup_valid_o stays 1, oup_data_o stable, credit unchanged.
REQ-033: rst_i pulsed during the 2nd beat of a 4-beat burst on input 1 -> next cycle IDLE, all readies 0, following grant starts scanning from input 0.
REQ-034: Build with STREAM_WRR_SCHEDULER_IDX_OUT_EN defined -> idx_o matches source index of every beat in REQ-029; build without -> port absent, REQ-029 result unchanged.
